// File: rtl/ex_ma_stage_reg.sv
// EX->MA pipeline register with valid/ready handshake, flush and bubble insertion.
// Define SKID_BUFFER_EN for a one-entry skid buffer with a registered in_ready.
module ex_ma_stage_reg #(
  parameter int XLEN    = 32,
  parameter int FUNC3_W = 3,
  parameter int RD_W    = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mem_write,
  input  logic               mem_read,
  input  logic               MUX3_select,
  input  logic               regwrite_enable,
  input  logic [XLEN-1:0]    ALU_out,
  input  logic [XLEN-1:0]    DATA_2,
  input  logic [FUNC3_W-1:0] func_3,
  input  logic [RD_W-1:0]    rd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               mem_write_out,
  output logic               mem_read_out,
  output logic               MUX3_select_out,
  output logic               regwrite_enable_out,
  output logic [XLEN-1:0]    ALU_out_out,
  output logic [XLEN-1:0]    DATA_2_out,
  output logic [FUNC3_W-1:0] func_3_out,
  output logic [RD_W-1:0]    rd_out
);

  typedef struct packed {
    logic               mem_write;
    logic               mem_read;
    logic               mux3_sel;
    logic               reg_we;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    data2;
    logic [FUNC3_W-1:0] func3;
    logic [RD_W-1:0]    rd;
  } ent_t;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_SKID = 2'd2
  } state_t;

  state_t state_q, state_d;
  ent_t   main_q, main_d;
  ent_t   in_ent;
  logic   accept;
  logic   drain;

`ifdef SKID_BUFFER_EN
  ent_t skid_q, skid_d;
  logic in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = (state_q == EMPTY) | out_ready;
`endif

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    in_ent           = '0;
    in_ent.mem_write = mem_write;
    in_ent.mem_read  = mem_read;
    in_ent.mux3_sel  = MUX3_select;
    in_ent.reg_we    = regwrite_enable;
    in_ent.alu       = ALU_out;
    in_ent.data2     = DATA_2;
    in_ent.func3     = func_3;
    in_ent.rd        = rd;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef SKID_BUFFER_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_ent;
            state_d = FULL;
          end
        end
        FULL: begin
          if (drain && accept) begin
            main_d = in_ent;
          end else if (drain) begin
            state_d = EMPTY;
`ifdef SKID_BUFFER_EN
          end else if (accept) begin
            skid_d  = in_ent;
            state_d = FULL_SKID;
`endif
          end
        end
        FULL_SKID: begin
`ifdef SKID_BUFFER_EN
          // main drains first; the parked entry then moves up
          if (drain) begin
            main_d  = skid_q;
            state_d = FULL;
          end
`else
          state_d = EMPTY;
`endif
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef SKID_BUFFER_EN
  always_comb begin
    in_ready_d = (state_d != FULL_SKID);
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= EMPTY;
      main_q  <= '0;
`ifdef SKID_BUFFER_EN
      skid_q     <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef SKID_BUFFER_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

  // control outs become a bubble whenever nothing valid is held
  assign mem_write_out       = main_q.mem_write & out_valid;
  assign mem_read_out        = main_q.mem_read & out_valid;
  assign MUX3_select_out     = main_q.mux3_sel & out_valid;
  assign regwrite_enable_out = main_q.reg_we & out_valid;
  assign ALU_out_out         = main_q.alu;
  assign DATA_2_out          = main_q.data2;
  assign func_3_out          = main_q.func3;
  assign rd_out              = main_q.rd;

  hold_stable_a: assert property (@(posedge CLK)
    RESET && out_valid && !out_ready && !flush
    |=> $stable(main_q) && $stable(out_valid));

endmodule

// File: tb/tb_ex_ma_stage_reg.sv
// Bench for ex_ma_stage_reg: directed vector table, queue reference model,
// random traffic and a wide-parameter capture check.
module tb_ex_ma_stage_reg;

`ifdef SKID_BUFFER_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic        mem_write, mem_read, mux3, regwr;
  logic [31:0] alu, d2;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        o_mw, o_mr, o_mux, o_rw;
  logic [31:0] o_alu, o_d2;
  logic [2:0]  o_f3;
  logic [4:0]  o_rd;

  ex_ma_stage_reg u_dut (
    .CLK(clk), .RESET(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .mem_write(mem_write), .mem_read(mem_read),
    .MUX3_select(mux3), .regwrite_enable(regwr),
    .ALU_out(alu), .DATA_2(d2), .func_3(f3), .rd(rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .mem_write_out(o_mw), .mem_read_out(o_mr),
    .MUX3_select_out(o_mux), .regwrite_enable_out(o_rw),
    .ALU_out_out(o_alu), .DATA_2_out(o_d2),
    .func_3_out(o_f3), .rd_out(o_rd)
  );

  logic        w_rst_n, w_flush, w_iv, w_ir, w_ov, w_ordy;
  logic        w_mw, w_mr, w_mux, w_rw;
  logic [63:0] w_alu, w_d2;
  logic [2:0]  w_f3;
  logic [5:0]  w_rd;
  logic        wo_mw, wo_mr, wo_mux, wo_rw;
  logic [63:0] wo_alu, wo_d2;
  logic [2:0]  wo_f3;
  logic [5:0]  wo_rd;

  ex_ma_stage_reg #(.XLEN(64), .FUNC3_W(3), .RD_W(6)) u_wide (
    .CLK(clk), .RESET(w_rst_n), .flush(w_flush),
    .in_valid(w_iv), .in_ready(w_ir),
    .mem_write(w_mw), .mem_read(w_mr),
    .MUX3_select(w_mux), .regwrite_enable(w_rw),
    .ALU_out(w_alu), .DATA_2(w_d2), .func_3(w_f3), .rd(w_rd),
    .out_valid(w_ov), .out_ready(w_ordy),
    .mem_write_out(wo_mw), .mem_read_out(wo_mr),
    .MUX3_select_out(wo_mux), .regwrite_enable_out(wo_rw),
    .ALU_out_out(wo_alu), .DATA_2_out(wo_d2),
    .func_3_out(wo_f3), .rd_out(wo_rd)
  );

  typedef struct packed {
    logic        mw, mr, mux, rw;
    logic [31:0] alu, d2;
    logic [2:0]  f3;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    bit          rst_n, fl, iv, ordy, mw, mr, rw;
    logic [4:0]  rd;
    logic [31:0] alu;
    bit          c, e_ov, e_ir, e_ctl;
    logic [4:0]  e_rd;
  } vec_t;

  ent_t q[$];
  ent_t shown;
  bit   model_ok = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tv[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, bit f, bit iv, bit od, bit mw, bit mr,
                              bit rw, logic [4:0] r_d, logic [31:0] a, bit c,
                              bit eov, bit eir, bit ectl, logic [4:0] erd);
    vec_t v;
    v.rst_n = r; v.fl = f; v.iv = iv; v.ordy = od;
    v.mw = mw; v.mr = mr; v.rw = rw; v.rd = r_d; v.alu = a;
    v.c = c; v.e_ov = eov; v.e_ir = eir; v.e_ctl = ectl; v.e_rd = erd;
    return v;
  endfunction

  // capacity two with skid (ready iff not full), else one slot that frees on drain
  function automatic bit model_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  task automatic step();
    ent_t h, e;
    bit   ov, ir;
    #1;
    ir = model_ready();
    if (model_ok) begin
      ov = (q.size() != 0);
      h  = ov ? q[0] : shown;
      chk("out_valid", 64'(out_valid), 64'(ov));
      chk("in_ready", 64'(in_ready), 64'(ir));
      chk("mem_write_out", 64'(o_mw), 64'(ov & h.mw));
      chk("mem_read_out", 64'(o_mr), 64'(ov & h.mr));
      chk("MUX3_select_out", 64'(o_mux), 64'(ov & h.mux));
      chk("regwrite_enable_out", 64'(o_rw), 64'(ov & h.rw));
      chk("ALU_out_out", 64'(o_alu), 64'(h.alu));
      chk("DATA_2_out", 64'(o_d2), 64'(h.d2));
      chk("func_3_out", 64'(o_f3), 64'(h.f3));
      chk("rd_out", 64'(o_rd), 64'(h.rd));
    end
    e = '{mem_write, mem_read, mux3, regwr, alu, d2, f3, rd};
    if (!rst_n) begin
      q.delete();
      shown    = '0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (in_valid && ir) q.push_back(e);
      end
      if (q.size() != 0) shown = q[0];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
    mem_write = 0; mem_read = 0; mux3 = 0; regwr = 0;
    alu = 0; d2 = 0; f3 = 0; rd = 0;
    w_rst_n = 0; w_flush = 0; w_iv = 0; w_ordy = 0;
    w_mw = 0; w_mr = 0; w_mux = 0; w_rw = 0;
    w_alu = 0; w_d2 = 0; w_f3 = 0; w_rd = 0;

    //            r f iv od mw mr rw rd  alu           c ov ir      ctl rd
    tv.push_back(mk(0,0,1,1,0,0,0, 9, 32'hDEADBEEF,0, 0,0,     0, 0));
    tv.push_back(mk(0,0,1,1,0,0,0, 9, 32'hDEADBEEF,1, 0,1,     0, 0));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0, 0));
    tv.push_back(mk(1,0,1,1,0,0,1, 1, 32'h10,      1, 0,1,     0, 0));
    tv.push_back(mk(1,0,1,1,0,0,1, 2, 32'h20,      1, 1,1,     1, 1));
    tv.push_back(mk(1,0,1,1,0,0,1, 3, 32'h30,      1, 1,1,     1, 2));
    tv.push_back(mk(1,0,1,1,0,0,1, 4, 32'h40,      1, 1,1,     1, 3));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 1,1,     1, 4));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0, 4));
    tv.push_back(mk(1,0,1,0,0,0,1, 7, 32'h70,      1, 0,1,     0, 4));
    tv.push_back(mk(1,0,1,0,0,0,1, 8, 32'h80,      1, 1,SKID,  1, 7));
    tv.push_back(mk(1,0,1,0,0,0,1, 8, 32'h80,      1, 1,0,     1, 7));
    tv.push_back(mk(1,0,1,0,0,0,1, 8, 32'h80,      1, 1,0,     1, 7));
    tv.push_back(mk(1,0,1,1,0,0,1, 8, 32'h80,      1, 1,!SKID, 1, 7));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 1,1,     1, 8));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0, 8));
    tv.push_back(mk(1,0,1,0,1,0,0,10, 32'hA0,      1, 0,1,     0, 8));
    tv.push_back(mk(1,0,1,0,1,0,0,11, 32'hB0,      1, 1,SKID,  1,10));
    tv.push_back(mk(1,1,1,0,1,0,0,12, 32'hC0,      1, 1,0,     1,10));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0,10));
    tv.push_back(mk(1,1,1,1,1,1,1,13, 32'hD0,      1, 0,1,     0,10));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0,10));
    tv.push_back(mk(1,0,0,1,0,1,1, 5, 32'h50,      1, 0,1,     0,10));
    tv.push_back(mk(1,0,0,1,0,1,1, 5, 32'h50,      1, 0,1,     0,10));
    tv.push_back(mk(1,0,1,1,0,0,1,14, 32'hE0,      1, 0,1,     0,10));
    tv.push_back(mk(0,1,1,1,1,0,1,15, 32'hF0,      1, 1,1,     1,14));
    tv.push_back(mk(1,0,0,1,0,0,0, 0, 32'h0,       1, 0,1,     0, 0));

    @(negedge clk);
    foreach (tv[i]) begin
      rst_n = tv[i].rst_n; flush = tv[i].fl;
      in_valid = tv[i].iv; out_ready = tv[i].ordy;
      mem_write = tv[i].mw; mem_read = tv[i].mr; regwr = tv[i].rw;
      mux3 = tv[i].rd[0]; rd = tv[i].rd; alu = tv[i].alu;
      d2 = ~tv[i].alu; f3 = tv[i].rd[2:0];
      #1;
      if (tv[i].c) begin
        chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tv[i].e_ov));
        chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tv[i].e_ir));
        chk($sformatf("vec%0d_ctl", i), 64'(o_mw | o_mr | o_mux | o_rw),
            64'(tv[i].e_ctl));
        chk($sformatf("vec%0d_rd_out", i), 64'(o_rd), 64'(tv[i].e_rd));
      end
      step();
    end

    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      mem_write = 1'($urandom_range(0, 1));
      mem_read  = 1'($urandom_range(0, 1));
      mux3      = 1'($urandom_range(0, 1));
      regwr     = 1'($urandom_range(0, 1));
      alu       = $urandom;
      d2        = $urandom;
      f3        = 3'($urandom_range(0, 7));
      rd        = 5'($urandom_range(0, 31));
      step();
    end

    rst_n = 0;
    w_rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    w_rst_n = 1; w_iv = 1; w_ordy = 1; w_mw = 1;
    w_alu = 64'hFFFF_0000_1234_5678;
    w_d2  = 64'h8000_0000_0000_0001;
    w_rd  = 6'd63; w_f3 = 3'd5;
    @(posedge clk);
    @(negedge clk);
    w_iv = 0; w_alu = 64'h0; w_d2 = 64'h0; w_rd = 6'd0; w_mw = 0;
    chk("wide_out_valid", 64'(w_ov), 64'd1);
    chk("wide_ALU_out", wo_alu, 64'hFFFF_0000_1234_5678);
    chk("wide_DATA_2", wo_d2, 64'h8000_0000_0000_0001);
    chk("wide_rd", 64'(wo_rd), 64'd63);
    chk("wide_func_3", 64'(wo_f3), 64'd5);
    chk("wide_mem_write", 64'(wo_mw), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("wide_drained_valid", 64'(w_ov), 64'd0);
    chk("wide_bubble_mw", 64'(wo_mw), 64'd0);
    chk("wide_hold_ALU_out", wo_alu, 64'hFFFF_0000_1234_5678);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
